// File: rtl/rule_grid_seq.sv
// Sequential fuzzy rule-weight generator: captures one frame of memberships and streams
// the NT x ND rule firing strengths row-major. Optional macro: RULE_GRID_PROD_EN (product t-norm).
module rule_grid_seq #(
  parameter int W  = 16,
  parameter int NT = 3,
  parameter int ND = 3,
  localparam int MX = (NT > ND) ? NT : ND,
  localparam int IW = (MX > 1) ? $clog2(MX) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NT*W-1:0] mu_t,
  input  logic [ND*W-1:0] mu_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_w,
  output logic [IW-1:0]   out_i,
  output logic [IW-1:0]   out_j,
  output logic            out_last
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  lat_t [NT];
  logic [W-1:0]  lat_d [ND];
  logic [IW-1:0] idx_i, idx_j, nxt_i, nxt_j;
  logic [W-1:0]  w_reg, w_nxt, w_min, op_a, op_b;
  logic          last_reg, last_nxt;
  logic          accept, fire, advance, finish;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RUN);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign advance   = fire && !last_reg;
  assign finish    = fire && last_reg;

  assign out_w    = w_reg;
  assign out_i    = idx_i;
  assign out_j    = idx_j;
  assign out_last = last_reg;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Row-major successor; i is clamped so the operand lookup never leaves the table on the last beat.
  always_comb begin
    nxt_i = idx_i;
    nxt_j = idx_j + 1'b1;
    if (idx_j == IW'(ND - 1)) begin
      nxt_j = '0;
      if (idx_i != IW'(NT - 1)) nxt_i = idx_i + 1'b1;
    end
  end

  // One t-norm datapath: fed from the live inputs at capture, from the latched frame while running.
  always_comb begin
    op_a     = lat_t[nxt_i];
    op_b     = lat_d[nxt_j];
    last_nxt = (nxt_i == IW'(NT - 1)) && (nxt_j == IW'(ND - 1));
    if (state == IDLE) begin
      op_a     = mu_t[W-1:0];
      op_b     = mu_d[W-1:0];
      last_nxt = (NT == 1) && (ND == 1);
    end
  end

  assign w_min = (op_a < op_b) ? op_a : op_b;

`ifdef RULE_GRID_PROD_EN
  logic         lat_mode, op_mode;
  logic [W-1:0] prod_hi;

  assign op_mode = (state == IDLE) ? mode : lat_mode;
  assign prod_hi = W'(({{W{1'b0}}, op_a} * {{W{1'b0}}, op_b}) >> W);

  // Full-scale operands pass the other side through exactly instead of losing an LSB to truncation.
  always_comb begin
    w_nxt = w_min;
    if (op_mode) begin
      if (op_a == '1)      w_nxt = op_b;
      else if (op_b == '1) w_nxt = op_a;
      else                 w_nxt = prod_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lat_mode <= 1'b0;
    else if (accept) lat_mode <= mode;
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign w_nxt       = w_min;
`endif

  // NOTE: the latched membership tables are reset too, so an aborted frame leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NT; k++) lat_t[k] <= '0;
      for (int k = 0; k < ND; k++) lat_d[k] <= '0;
      idx_i    <= '0;
      idx_j    <= '0;
      w_reg    <= '0;
      last_reg <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < NT; k++) lat_t[k] <= mu_t[k*W +: W];
      for (int k = 0; k < ND; k++) lat_d[k] <= mu_d[k*W +: W];
      idx_i    <= '0;
      idx_j    <= '0;
      w_reg    <= w_nxt;
      last_reg <= last_nxt;
    end else if (advance) begin
      idx_i    <= nxt_i;
      idx_j    <= nxt_j;
      w_reg    <= w_nxt;
      last_reg <= last_nxt;
    end else if (finish) begin
      last_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rule_grid_seq.sv
// Self-checking bench for rule_grid_seq: a 3x3 and a 2x4 instance against a row-major
// beat-list model; honours RULE_GRID_PROD_EN the same way the design does.
module tb_rule_grid_seq;

`ifdef RULE_GRID_PROD_EN
  localparam bit PROD_EN = 1'b1;
`else
  localparam bit PROD_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] w;
    int          i;
    int          j;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, mode, iv, sel, ordy;
  logic [15:0] tv [4];
  logic [15:0] dv [4];

  logic        r1, v1, l1, r2, v2, l2;
  logic [15:0] w1, w2;
  logic [1:0]  i1, j1, i2, j2;
  logic        ir, ov, ol;
  logic [15:0] ow;
  logic [1:0]  oi, oj;

  beat_t exp_q[$];
  int    nvec  = 0;
  int    nfail = 0;

  always #5 clk = ~clk;

  rule_grid_seq #(.W(16), .NT(3), .ND(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(iv & ~sel), .in_ready(r1),
    .mu_t({tv[2], tv[1], tv[0]}), .mu_d({dv[2], dv[1], dv[0]}),
    .out_valid(v1), .out_ready(ordy), .out_w(w1), .out_i(i1), .out_j(j1), .out_last(l1)
  );

  rule_grid_seq #(.W(16), .NT(2), .ND(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(iv & sel), .in_ready(r2),
    .mu_t({tv[1], tv[0]}), .mu_d({dv[3], dv[2], dv[1], dv[0]}),
    .out_valid(v2), .out_ready(ordy), .out_w(w2), .out_i(i2), .out_j(j2), .out_last(l2)
  );

  assign ir = sel ? r2 : r1;
  assign ov = sel ? v2 : v1;
  assign ow = sel ? w2 : w1;
  assign oi = sel ? i2 : i1;
  assign oj = sel ? j2 : j1;
  assign ol = sel ? l2 : l1;

  function automatic logic [15:0] model_w(input logic [15:0] a, input logic [15:0] b, input logic m);
    int unsigned p;
    if (PROD_EN && m) begin
      if (a == 16'hFFFF) return b;
      if (b == 16'hFFFF) return a;
      p = int'(a) * int'(b);
      return p[31:16];
    end
    return (a < b) ? a : b;
  endfunction

  task automatic build(input int nt, input int nd, input logic m);
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < nt; i++)
      for (int j = 0; j < nd; j++) begin
        b.w = model_w(tv[i], dv[j], m);
        b.i = i;
        b.j = j;
        b.last = (i == nt - 1) && (j == nd - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic rand_data();
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 5))
        0:       tv[k] = 16'hFFFF;
        1:       tv[k] = 16'h0000;
        default: tv[k] = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       dv[k] = 16'hFFFF;
        1:       dv[k] = 16'h0000;
        default: dv[k] = 16'($urandom);
      endcase
    end
  endtask

  // Offer a frame for one cycle, then scramble inputs to prove only the captured copy is used.
  task automatic send(input logic m);
    mode = m;
    iv   = 1'b1;
    @(negedge clk);
    iv   = 1'b0;
    mode = ~m;
    rand_data();
  endtask

  task automatic collect(input int max_pop, input int stall_k, input int stall_n,
                         input bit rnd, output int cycles);
    int    popped = 0;
    int    stall_left = stall_n;
    bit    r;
    beat_t e;
    cycles = 0;
    while (exp_q.size() > 0 && popped < max_pop) begin
      if (cycles > 400) begin
        nvec++; nfail++;
        $display("FAIL timeout: %0d beats still expected after %0d cycles", exp_q.size(), cycles);
        exp_q.delete();
        break;
      end
      e = exp_q[0];
      nvec++;
      if (ov !== 1'b1 || ow !== e.w || oi !== 2'(e.i) || oj !== 2'(e.j) || ol !== e.last) begin
        nfail++;
        $display("FAIL beat: got v=%b w=%h i=%0d j=%0d last=%b, want v=1 w=%h i=%0d j=%0d last=%b",
                 ov, ow, oi, oj, ol, e.w, e.i, e.j, e.last);
      end
      nvec++;
      if (ir !== 1'b0) begin
        nfail++;
        $display("FAIL ready_in_run: in_ready=%b, want 0", ir);
      end
      r = 1'b1;
      if (popped == stall_k && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else if (rnd) begin
        r = ($urandom_range(0, 3) != 0);
      end
      ordy = r;
      if (r) begin
        void'(exp_q.pop_front());
        popped++;
      end
      @(negedge clk);
      cycles++;
    end
    ordy = 1'b1;
  endtask

  task automatic end_check(input string name);
    nvec++;
    if (ov !== 1'b0 || ir !== 1'b1 || ol !== 1'b0) begin
      nfail++;
      $display("FAIL %s_idle: out_valid=%b in_ready=%b out_last=%b, want 0 1 0", name, ov, ir, ol);
    end
  endtask

  task automatic check_count(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s_cycles: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_reset_vals(input string name);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #0;
      nvec++;
      if (ir !== 1'b1 || ov !== 1'b0 || ow !== 16'h0 || oi !== 2'd0 || oj !== 2'd0 || ol !== 1'b0) begin
        nfail++;
        $display("FAIL %s dut%0d: ready=%b valid=%b w=%h i=%0d j=%0d last=%b, want 1 0 0000 0 0 0",
                 name, d + 1, ir, ov, ow, oi, oj, ol);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; iv = 1'b0; ordy = 1'b1; sel = 1'b0; mode = 1'b0;
    rand_data();
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_min_directed();
    int cyc;
    tv[0] = 16'h8000; tv[1] = 16'h4000; tv[2] = 16'h0000;
    dv[0] = 16'hFFFF; dv[1] = 16'h2000; dv[2] = 16'h6000;
    build(3, 3, 1'b0);
    send(1'b0);
    collect(99, -1, 0, 1'b0, cyc);
    check_count("min_directed", cyc, 9);
    end_check("min_directed");
  endtask

  task automatic test_product();
    int cyc;
    tv[0] = 16'h8000; tv[1] = 16'hFFFF; tv[2] = 16'h3333;
    dv[0] = 16'h8000; dv[1] = 16'h4000; dv[2] = 16'hFFFF;
    build(3, 3, 1'b1);
    send(1'b1);
    collect(99, -1, 0, 1'b0, cyc);
    end_check("product_a");
    tv[0] = 16'h8000; tv[1] = 16'hFFFF; tv[2] = 16'hFFFF;
    dv[0] = 16'h1234; dv[1] = 16'h4000; dv[2] = 16'hFFFF;
    build(3, 3, 1'b1);
    send(1'b1);
    collect(99, -1, 0, 1'b0, cyc);
    end_check("product_b");
  endtask

  task automatic test_backpressure();
    int cyc;
    rand_data();
    build(3, 3, 1'b1);
    send(1'b1);
    collect(99, 4, 3, 1'b0, cyc);
    check_count("backpressure", cyc, 12);
    end_check("backpressure");
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic mb;
    rand_data();
    build(3, 3, 1'b0);
    mode = 1'b0;
    iv   = 1'b1;
    @(negedge clk);
    rand_data();
    mb   = 1'($urandom);
    mode = mb;
    collect(99, -1, 0, 1'b1, cyc);
    nvec++;
    if (ir !== 1'b1) begin
      nfail++;
      $display("FAIL b2b_accept: in_ready=%b after last beat, want 1", ir);
    end
    build(3, 3, mb);
    @(negedge clk);
    iv = 1'b0;
    collect(99, -1, 0, 1'b0, cyc);
    check_count("b2b_second", cyc, 9);
    end_check("b2b");
  endtask

  task automatic test_reset_mid();
    int cyc;
    rand_data();
    build(3, 3, 1'b1);
    send(1'b1);
    collect(3, -1, 0, 1'b0, cyc);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_mid");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_data();
    build(3, 3, 1'b0);
    send(1'b0);
    collect(99, -1, 0, 1'b0, cyc);
    check_count("reset_mid_fresh", cyc, 9);
    end_check("reset_mid");
  endtask

  task automatic test_random();
    int   cyc;
    logic m;
    for (int f = 0; f < 8; f++) begin
      rand_data();
      m = 1'($urandom);
      build(3, 3, m);
      send(m);
      collect(99, -1, 0, 1'b1, cyc);
      end_check("random");
    end
  endtask

  task automatic test_nonsquare();
    int cyc;
    sel = 1'b1;
    @(negedge clk);
    rand_data();
    tv[1] = 16'hFFFF;
    build(2, 4, 1'b1);
    send(1'b1);
    collect(99, -1, 0, 1'b0, cyc);
    check_count("nonsquare", cyc, 8);
    end_check("nonsquare");
    for (int f = 0; f < 3; f++) begin
      rand_data();
      build(2, 4, f[0]);
      send(f[0]);
      collect(99, 2, 2, 1'b1, cyc);
      end_check("nonsquare_rand");
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_min_directed();
    test_product();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_nonsquare();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
